// File: rtl/adder_arbiter.sv
// Round-robin arbiter feeding a single-slot registered adder.
// One granted requester per cycle; result held until out_ready and retired with no bubble.
module adder_arbiter #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   req_in1,
    input  logic [NREQ*WIDTH-1:0]   req_in2,
    output logic [NREQ-1:0]         gnt,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_sum,
    output logic                    out_carry,
    output logic [IDW-1:0]          out_id
);

    generate
        if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
            $error("adder_arbiter: NREQ must be in 2..8");
        end
    endgenerate

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [IDW-1:0]   ptr_q, ptr_d;

    logic             slot_free;
    logic             found;
    logic [IDW-1:0]   gidx;
    int               rr_idx;
    logic [WIDTH-1:0] op_a, op_b;
    logic [WIDTH:0]   sum_full;

    assign slot_free = (state_q == EMPTY) || out_ready;

    // Scan from ptr upward with wrap; the first asserted request wins.
    always_comb begin
        found  = 1'b0;
        gidx   = '0;
        rr_idx = 0;
        gnt    = '0;
        if (!rst && slot_free) begin
            for (int k = 0; k < NREQ; k++) begin
                rr_idx = int'(ptr_q) + k;
                if (rr_idx >= NREQ) rr_idx = rr_idx - NREQ;
                if (!found && req[rr_idx[IDW-1:0]]) begin
                    found = 1'b1;
                    gidx  = rr_idx[IDW-1:0];
                end
            end
        end
        if (found) gnt[gidx] = 1'b1;
    end

    assign op_a     = req_in1[gidx*WIDTH +: WIDTH];
    assign op_b     = req_in2[gidx*WIDTH +: WIDTH];
    assign sum_full = {1'b0, op_a} + {1'b0, op_b};

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        case (state_q)
            EMPTY: if (found) state_d = FULL;
            FULL:  if (out_ready) state_d = found ? FULL : EMPTY;
            default: state_d = EMPTY;
        endcase
        // A grant implies the slot is free, so loading here never overwrites an unaccepted result.
        if (found) begin
            sum_d   = sum_full[WIDTH-1:0];
            carry_d = sum_full[WIDTH];
            id_d    = gidx;
            ptr_d   = (int'(gidx) == NREQ - 1) ? '0 : gidx + IDW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            sum_q   <= '0;
            carry_q <= 1'b0;
            id_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_sum   = sum_q;
    assign out_carry = carry_q;
    assign out_id    = id_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: reset, round-robin order, carry, backpressure, mid-run reset, wrap, dropped requests.
module tb_adder_arbiter;
    localparam int W    = 32;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*W-1:0]     req_in1;
    logic [NREQ*W-1:0]     req_in2;
    logic [NREQ-1:0]       gnt;
    logic                  out_valid;
    logic                  out_ready;
    logic [W-1:0]          out_sum;
    logic                  out_carry;
    logic [IDW-1:0]        out_id;

    int n_checks = 0;
    int n_fail   = 0;

    adder_arbiter #(.WIDTH(W), .NREQ(NREQ)) dut (
        .clk(clk), .rst(rst), .req(req), .req_in1(req_in1), .req_in2(req_in2),
        .gnt(gnt), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_carry(out_carry), .out_id(out_id)
    );

    always #5 clk = ~clk;

    // Stimulus helpers; every task starts and ends just after a falling edge.
    task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_in1[i*W +: W] = a;
        req_in2[i*W +: W] = b;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1; req = '0; out_ready = 1'b1;
        repeat (cycles) begin @(posedge clk); @(negedge clk); end
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; out_ready = 1'b1;
        #1;
        n_checks++;
        if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        repeat (3) begin @(posedge clk); @(negedge clk); end
        n_checks++;
        if (out_valid !== 1'b0 || out_sum !== '0 || out_carry !== 1'b0 || out_id !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: got v=%b s=%0d c=%b id=%0d want 0 0 0 0", out_valid, out_sum, out_carry, out_id);
        end
        rst = 1'b0; req = '0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_idle_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_single();
        do_reset(1);
        set_ops(0, 32'd5, 32'd7);
        req = 4'b0001;
        #1;
        n_checks++;
        if (gnt !== 4'b0001) begin n_fail++; $display("FAIL single_gnt: got %b want 0001", gnt); end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_sum !== 32'd12 || out_carry !== 1'b0 || out_id !== 2'd0) begin
            n_fail++;
            $display("FAIL single_result: got v=%b s=%0d c=%b id=%0d want 1 12 0 0", out_valid, out_sum, out_carry, out_id);
        end
        @(negedge clk);
        req = 4'b0000;
        #1;
        n_checks++;
        if (gnt !== 4'b0000) begin n_fail++; $display("FAIL single_idle_gnt: got %b want 0000", gnt); end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_retire: got valid %b want 0", out_valid); end
        @(negedge clk);
        req = 4'b1111;
        #1;
        n_checks++;
        if (gnt !== 4'b0010) begin n_fail++; $display("FAIL single_ptr_next: got %b want 0010", gnt); end
        @(negedge clk);
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        do_reset(1);
        for (int i = 0; i < NREQ; i++) set_ops(i, 32'(i * 10), 32'd1);
        req = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            int exp_id;
            exp_id = c % NREQ;
            #1;
            n_checks++;
            if (gnt !== 4'(1 << exp_id)) begin
                n_fail++; $display("FAIL rr_gnt[%0d]: got %b want %b", c, gnt, 4'(1 << exp_id));
            end
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_id !== 2'(exp_id) || out_sum !== 32'(exp_id * 10 + 1)) begin
                n_fail++;
                $display("FAIL rr_out[%0d]: got v=%b id=%0d s=%0d want 1 %0d %0d", c, out_valid, out_id, out_sum, exp_id, exp_id * 10 + 1);
            end
            @(negedge clk);
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_carry();
        do_reset(1);
        set_ops(2, 32'hFFFF_FFFF, 32'd1);
        req = 4'b0100;
        #1;
        n_checks++;
        if (gnt !== 4'b0100) begin n_fail++; $display("FAIL carry_gnt: got %b want 0100", gnt); end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_sum !== 32'd0 || out_carry !== 1'b1 || out_id !== 2'd2) begin
            n_fail++;
            $display("FAIL carry_result: got v=%b s=%0d c=%b id=%0d want 1 0 1 2", out_valid, out_sum, out_carry, out_id);
        end
        @(negedge clk);
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        do_reset(1);
        set_ops(0, 32'd5, 32'd7);
        set_ops(1, 32'd100, 32'd23);
        req = 4'b0001;
        @(negedge clk);
        req = 4'b0010; out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (gnt !== 4'b0000) begin n_fail++; $display("FAIL bp_gnt[%0d]: got %b want 0000", c, gnt); end
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_sum !== 32'd12 || out_id !== 2'd0 || out_carry !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got v=%b s=%0d id=%0d want 1 12 0", c, out_valid, out_sum, out_id);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (gnt !== 4'b0010) begin n_fail++; $display("FAIL bp_release_gnt: got %b want 0010", gnt); end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_sum !== 32'd123 || out_id !== 2'd1) begin
            n_fail++;
            $display("FAIL bp_new: got v=%b s=%0d id=%0d want 1 123 1", out_valid, out_sum, out_id);
        end
        @(negedge clk);
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        do_reset(1);
        set_ops(1, 32'd3, 32'd4);
        set_ops(2, 32'd9, 32'd9);
        set_ops(3, 32'd1, 32'd1);
        req = 4'b0100;             // grant 2 leaves ptr at 3
        @(negedge clk);
        req = '0; out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_id !== 2'd0 || out_sum !== '0) begin
            n_fail++;
            $display("FAIL midrst_clear: got v=%b id=%0d s=%0d want 0 0 0", out_valid, out_id, out_sum);
        end
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1; req = 4'b1010;
        #1;
        n_checks++;
        if (gnt !== 4'b0010) begin n_fail++; $display("FAIL midrst_gnt: got %b want 0010", gnt); end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_id !== 2'd1 || out_sum !== 32'd7) begin
            n_fail++;
            $display("FAIL midrst_result: got v=%b id=%0d s=%0d want 1 1 7", out_valid, out_id, out_sum);
        end
        @(negedge clk);
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        do_reset(1);
        set_ops(0, 32'd40, 32'd2);
        set_ops(2, 32'd20, 32'd5);
        req = 4'b0100;
        @(negedge clk);
        req = 4'b0101;
        #1;
        n_checks++;
        if (gnt !== 4'b0001) begin n_fail++; $display("FAIL wrap_gnt: got %b want 0001", gnt); end
        @(posedge clk); #1;
        n_checks++;
        if (out_id !== 2'd0 || out_sum !== 32'd42) begin
            n_fail++; $display("FAIL wrap_result: got id=%0d s=%0d want 0 42", out_id, out_sum);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (gnt !== 4'b0100) begin n_fail++; $display("FAIL wrap_next_gnt: got %b want 0100", gnt); end
        @(negedge clk);
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_drop();
        do_reset(1);
        set_ops(0, 32'd1, 32'd2);
        set_ops(1, 32'd50, 32'd50);
        req = 4'b0001;
        @(negedge clk);
        req = 4'b0010; out_ready = 1'b0;
        @(negedge clk);
        req = 4'b0000; out_ready = 1'b1;
        #1;
        n_checks++;
        if (gnt !== 4'b0000) begin n_fail++; $display("FAIL drop_gnt: got %b want 0000", gnt); end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drop_valid: got %b want 0", out_valid); end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; req = '0; out_ready = 1'b1; req_in1 = '0; req_in2 = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_carry();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        test_drop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand and sum width in bits.
REQ-002 Parameter NREQ, default 4, number of requesters; the block SHALL support exactly 2..8.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req  input  NREQ  per-requester request; bit i held high until granted.
REQ-006 req_in1  input  NREQ*WIDTH  operand A; requester i in bits [i*WIDTH +: WIDTH].
REQ-007 req_in2  input  NREQ*WIDTH  operand B; same packing as req_in1.
REQ-008 gnt  output  NREQ  one-hot grant, combinational, valid in the capture cycle.
REQ-009 out_valid  output  1  registered result valid.
REQ-010 out_ready  input  1  consumer accepts the result when out_valid and out_ready are both high.
REQ-011 out_sum  output  WIDTH  registered (in1 + in2) mod 2^WIDTH.
REQ-012 out_carry  output  1  registered carry-out of the addition.
REQ-013 out_id  output  clog2(NREQ)  index of the requester that owns out_sum.

Function
REQ-014 The block SHALL hold two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-015 The slot is free in a cycle when state is EMPTY, or when state is FULL and out_ready=1.
REQ-016 When the slot is free and req != 0, gnt SHALL assert exactly one bit, chosen round-robin from pointer ptr: the first set req bit at index ptr, ptr+1, ..., wrapping modulo NREQ.
REQ-017 When the slot is not free, or req == 0, gnt SHALL be all zeros.
REQ-018 At the edge ending a grant cycle for requester i, the block SHALL register out_sum, out_carry and out_id=i from that requester's operands, set out_valid=1, and set ptr=(i+1) mod NREQ.
REQ-019 Latency SHALL be one cycle: a result granted in cycle n is presented with out_valid=1 in cycle n+1.
REQ-020 In FULL with out_ready=1 and a grant in the same cycle, the old result SHALL be retired and the new one loaded at the same edge; out_valid SHALL stay 1, giving one result per cycle with no bubble.
REQ-021 In FULL with out_ready=1 and no grant, the state SHALL go to EMPTY with out_valid=0.
REQ-022 In FULL with out_ready=0, out_sum, out_carry and out_id SHALL hold stable, and no grant SHALL issue.
REQ-023 ptr SHALL change only on a grant.
REQ-024 A requester whose req drops before it is granted SHALL receive no grant, and no result SHALL be produced for it.
REQ-025 Arithmetic SHALL be unsigned and computed as a WIDTH+1-bit sum; bit WIDTH drives out_carry.
REQ-026 Fairness: with all requesters continuously requesting and out_ready=1, each requester SHALL be granted exactly once in every NREQ consecutive grants.

Reset
REQ-027 While rst=1 at a clock edge, the edge SHALL set state EMPTY, out_valid=0, out_sum=0, out_carry=0, out_id=0 and ptr=0.
REQ-028 While rst=1, gnt SHALL be all zeros regardless of req.
REQ-029 Reset asserted mid-operation SHALL discard any held result; no out_valid/out_ready handshake SHALL complete for it after rst deasserts.
REQ-030 Behaviour SHALL be identical for reset asserted for one cycle or for several cycles.

Verification
REQ-031 After reset, req=4'b0001, in1=5, in2=7, out_ready=1: gnt=4'b0001 in cycle 0; cycle 1 gives out_valid=1, out_sum=12, out_carry=0, out_id=0; ptr=1.
REQ-032 After reset, req=4'b1111 held with out_ready=1: grant order 0,1,2,3,0 on consecutive cycles, out_valid stays 1 throughout, out_id follows the same order one cycle later.
REQ-033 Requester 2 with in1=32'hFFFF_FFFF, in2=1: out_sum=0, out_carry=1, out_id=2.
REQ-034 FULL holding sum 12, out_ready=0 for 3 cycles with req=4'b0010: gnt=0 and outputs stable for all 3 cycles; gnt=4'b0010 in the cycle out_ready rises, new result in the next cycle.
REQ-035 FULL with out_ready=0, rst pulsed for one cycle: out_valid=0 and ptr=0 after the edge; with req=4'b1010 next cycle, gnt=4'b0010.
REQ-036 ptr=3, req=4'b0101: gnt=4'b0001 (wrap-around), then ptr=1, so the next grant goes to requester 2.
